// File: rtl/mrv32_if.sv
// Instruction fetch stage for a single-issue RV32 core: one request in flight,
// holds the fetched word until writeback commits it, halts sticky on any fault.
module mrv32_if #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        instr_accept,
  input  logic [31:0] pc_next,
  output logic        fetch_fault,
  output logic [31:0] fault_pc,
  output logic [31:0] retire_count
);

  // state      | meaning
  // S_REQ      | request at pc presented, waiting for imem_req_ready
  // S_WAIT_RSP | request accepted, waiting for the response beat
  // S_HOLD     | instruction held for decode/execute until instr_accept
  // S_FAULT    | bus error or misaligned next pc; halted until rst
  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT_RSP,
    S_HOLD,
    S_FAULT
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic        ld_instr;
  logic        ld_pc;
  logic        ld_fault;
  logic        inc_retire;
  logic [31:0] fault_pc_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_REQ;
      pc           <= RESET_PC;
      if_instr     <= 32'h0;
      fault_pc     <= 32'h0;
      retire_count <= 32'h0;
    end else begin
      state <= state_nxt;
      if (ld_instr)   if_instr     <= imem_rsp_data;
      if (ld_pc)      pc           <= pc_next;
      if (ld_fault)   fault_pc     <= fault_pc_nxt;
      if (inc_retire) retire_count <= retire_count + 32'd1;
    end
  end

  always_comb begin
    state_nxt    = state;
    ld_instr     = 1'b0;
    ld_pc        = 1'b0;
    ld_fault     = 1'b0;
    inc_retire   = 1'b0;
    fault_pc_nxt = pc;
    case (state)
      S_REQ: begin
        if (imem_req_ready) state_nxt = S_WAIT_RSP;
      end
      S_WAIT_RSP: begin
        if (imem_rsp_valid) begin
          if (imem_rsp_err) begin
            ld_fault  = 1'b1;
            state_nxt = S_FAULT;
          end else begin
            ld_instr  = 1'b1;
            state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (instr_accept) begin
          inc_retire = 1'b1;
          if (pc_next[1:0] == 2'b00) begin
            ld_pc     = 1'b1;
            state_nxt = S_REQ;
          end else begin
            // pc stays at the committed instruction; the bad target is reported
            ld_fault     = 1'b1;
            fault_pc_nxt = pc_next;
            state_nxt    = S_FAULT;
          end
        end
      end
      S_FAULT: begin
        state_nxt = S_FAULT;
      end
      default: begin
        state_nxt = S_REQ;
      end
    endcase
  end

  // Reset state is S_REQ, so the request is gated by rst to stay quiet during reset.
  assign imem_req_valid = (state == S_REQ) && !rst;
  assign imem_req_addr  = pc;
  assign if_valid       = (state == S_HOLD);
  assign if_pc          = pc;
  assign fetch_fault    = (state == S_FAULT);

endmodule

// File: tb/tb_mrv32_if.sv
// Bench for mrv32_if: directed scenarios followed by a randomized fetch/commit walk,
// checked against a transaction-level model of pc, held instruction, retire count and fault.
module tb_mrv32_if;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        imem_rsp_err = 1'b0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        instr_accept = 1'b0;
  logic [31:0] pc_next = 32'h0;
  logic        fetch_fault;
  logic [31:0] fault_pc;
  logic [31:0] retire_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_retire;
  logic [31:0] m_fault_pc;
  logic        m_fault;

  mrv32_if #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .instr_accept   (instr_accept),
    .pc_next        (pc_next),
    .fetch_fault    (fetch_fault),
    .fault_pc       (fault_pc),
    .retire_count   (retire_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    instr_accept   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_if_valid", if_valid, 1'b0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_if_pc", if_pc, RST_PC);
    chk("rst_fault", fetch_fault, 1'b0);
    chk("rst_fault_pc", fault_pc, 32'h0);
    chk("rst_retire", retire_count, 32'h0);
    rst = 1'b0;
    #1;
    m_pc = RST_PC; m_instr = 32'h0; m_retire = 32'h0; m_fault = 1'b0; m_fault_pc = 32'h0;
    chk("post_rst_req_valid", imem_req_valid, 1'b1);
    chk("post_rst_req_addr", imem_req_addr, RST_PC);
  endtask

  // Request phase with stall cycles (spurious rsp/accept injected), then response after rdly cycles.
  task automatic fetch(input int stall, input int rdly, input logic [31:0] data, input logic err);
    chk("req_valid", imem_req_valid, 1'b1);
    chk("req_addr", imem_req_addr, m_pc);
    for (int i = 0; i < stall; i++) begin
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'($urandom_range(0, 1));
      imem_rsp_data  = $urandom;
      instr_accept   = 1'($urandom_range(0, 1));
      pc_next        = $urandom;
      @(negedge clk);
      chk("stall_req_valid", imem_req_valid, 1'b1);
      chk("stall_req_addr", imem_req_addr, m_pc);
      chk("stall_if_valid", if_valid, 1'b0);
      chk("stall_retire", retire_count, m_retire);
    end
    idle_inputs();
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    chk("wait_req_valid", imem_req_valid, 1'b0);
    for (int i = 0; i < rdly; i++) begin
      instr_accept = 1'($urandom_range(0, 1));
      pc_next      = $urandom;
      @(negedge clk);
      chk("wait_req_valid", imem_req_valid, 1'b0);
      chk("wait_if_valid", if_valid, 1'b0);
    end
    instr_accept   = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    imem_rsp_err   = err;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    chk("rsp_retire", retire_count, m_retire);
    if (err) begin
      m_fault = 1'b1; m_fault_pc = m_pc;
      chk("err_fault", fetch_fault, 1'b1);
      chk("err_fault_pc", fault_pc, m_fault_pc);
      chk("err_if_valid", if_valid, 1'b0);
      chk("err_req_valid", imem_req_valid, 1'b0);
    end else begin
      m_instr = data;
      chk("hold_if_valid", if_valid, 1'b1);
      chk("hold_if_instr", if_instr, m_instr);
      chk("hold_if_pc", if_pc, m_pc);
      chk("hold_fault", fetch_fault, 1'b0);
    end
  endtask

  // Hold for dly cycles with stray responses, then commit with the given next pc.
  task automatic commit(input int dly, input logic [31:0] nxt);
    for (int i = 0; i < dly; i++) begin
      imem_rsp_valid = 1'($urandom_range(0, 1));
      imem_rsp_data  = $urandom;
      imem_rsp_err   = 1'($urandom_range(0, 1));
      imem_req_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("hold_stable_valid", if_valid, 1'b1);
      chk("hold_stable_instr", if_instr, m_instr);
      chk("hold_stable_pc", if_pc, m_pc);
      chk("hold_no_req", imem_req_valid, 1'b0);
    end
    idle_inputs();
    instr_accept = 1'b1;
    pc_next      = nxt;
    @(negedge clk);
    instr_accept = 1'b0;
    m_retire = m_retire + 32'd1;
    chk("commit_retire", retire_count, m_retire);
    chk("commit_if_valid", if_valid, 1'b0);
    if (nxt % 4 == 0) begin
      m_pc = nxt;
      chk("commit_req_valid", imem_req_valid, 1'b1);
      chk("commit_req_addr", imem_req_addr, m_pc);
      chk("commit_fault", fetch_fault, 1'b0);
    end else begin
      m_fault = 1'b1; m_fault_pc = nxt;
      chk("mis_fault", fetch_fault, 1'b1);
      chk("mis_fault_pc", fault_pc, m_fault_pc);
      chk("mis_pc_kept", if_pc, m_pc);
      chk("mis_req_valid", imem_req_valid, 1'b0);
    end
  endtask

  task automatic fault_idle(input int n);
    for (int i = 0; i < n; i++) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      imem_rsp_valid = 1'($urandom_range(0, 1));
      imem_rsp_data  = $urandom;
      instr_accept   = 1'($urandom_range(0, 1));
      pc_next        = $urandom;
      @(negedge clk);
      chk("flt_req_valid", imem_req_valid, 1'b0);
      chk("flt_if_valid", if_valid, 1'b0);
      chk("flt_sticky", fetch_fault, 1'b1);
      chk("flt_fault_pc", fault_pc, m_fault_pc);
      chk("flt_retire", retire_count, m_retire);
    end
    idle_inputs();
  endtask

  initial begin
    // Basic loop at minimum latency
    do_reset();
    fetch(0, 0, 32'h0000_0013, 1'b0);
    commit(0, 32'h0000_0004);
    // Five-cycle request stall with ignored stray inputs, then jump to 0x80
    fetch(5, 0, 32'h0000_0093, 1'b0);
    commit(1, 32'h0000_0080);
    // Bus error at 0x80
    fetch(0, 1, 32'hDEAD_BEEF, 1'b1);
    fault_idle(4);

    // Misaligned next pc on commit
    do_reset();
    fetch(0, 0, 32'h0000_0113, 1'b0);
    commit(0, 32'h0000_0100);
    fetch(1, 2, 32'h0000_0193, 1'b0);
    commit(2, 32'h0000_0102);
    fault_idle(3);

    // retire_count wraps from all-ones to zero
    do_reset();
    fetch(0, 0, 32'h0000_0213, 1'b0);
    force dut.retire_count = 32'hFFFF_FFFF;
    #1;
    release dut.retire_count;
    m_retire = 32'hFFFF_FFFF;
    commit(0, 32'h0000_0008);
    chk("wrap_zero", retire_count, 32'h0);

    // Reset during WAIT_RSP, late response afterwards must be ignored
    do_reset();
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    chk("pre_abort_req_valid", imem_req_valid, 1'b0);
    rst = 1'b1;
    #1;
    chk("abort_req_valid", imem_req_valid, 1'b0);
    chk("abort_if_valid", if_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_0001;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    m_pc = RST_PC; m_retire = 32'h0; m_fault = 1'b0; m_instr = 32'h0;
    chk("late_if_valid", if_valid, 1'b0);
    chk("late_if_instr", if_instr, 32'h0);
    chk("late_fault", fetch_fault, 1'b0);
    fetch(0, 0, 32'h0000_0313, 1'b0);
    commit(0, 32'h0000_000C);

    // Randomized walk
    for (int it = 0; it < 60; it++) begin
      logic        err;
      logic [31:0] nxt;
      err = ($urandom_range(0, 15) == 0);
      fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom, err);
      if (!err) begin
        nxt = {$urandom_range(0, 32'h3FFF), 2'b00};
        if ($urandom_range(0, 9) == 0) nxt[1:0] = 2'($urandom_range(1, 3));
        commit($urandom_range(0, 3), nxt);
      end
      if (m_fault) begin
        fault_idle($urandom_range(1, 3));
        do_reset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mrv32_if.md
MRV32_IF -- requirements
Module: mrv32_if

Interface
REQ-001 Parameter RESET_PC SHALL exist; default 32'h0000_0000; meaning: PC fetched first after reset (word-aligned).
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 imem_req_valid  out  1  instruction-memory request valid.
REQ-005 imem_req_addr  out  32  request address (current PC).
REQ-006 imem_req_ready  in  1  memory accepts request when high with imem_req_valid.
REQ-007 imem_rsp_valid  in  1  response data valid.
REQ-008 imem_rsp_data  in  32  fetched instruction word.
REQ-009 imem_rsp_err  in  1  response carries bus error (qualified by imem_rsp_valid).
REQ-010 if_valid  out  1  fetched instruction held for decode/execute.
REQ-011 if_instr  out  32  held instruction word.
REQ-012 if_pc  out  32  PC of held instruction.
REQ-013 instr_accept  in  1  commit pulse from writeback stage.
REQ-014 pc_next  in  32  next PC from writeback stage, qualified by instr_accept.
REQ-015 fetch_fault  out  1  sticky fault flag; fetch halted.
REQ-016 fault_pc  out  32  PC that caused the fault.
REQ-017 retire_count  out  32  count of accepted instructions.

Function
REQ-018 The block SHALL implement FSM states REQ, WAIT_RSP, HOLD, FAULT; one instruction in flight at any time.
REQ-019 REQ: imem_req_valid=1, imem_req_addr=pc; on imem_req_ready SHALL go to WAIT_RSP next cycle; else remain in REQ with address stable.
REQ-020 imem_req_valid SHALL be 0 in every state except REQ.
REQ-021 WAIT_RSP: on imem_rsp_valid && !imem_rsp_err SHALL latch if_instr<=imem_rsp_data, go to HOLD; if_valid high from the following cycle.
REQ-022 WAIT_RSP: on imem_rsp_valid && imem_rsp_err SHALL go to FAULT, fault_pc<=pc.
REQ-023 imem_rsp_valid outside WAIT_RSP SHALL be ignored (no state, data or flag change).
REQ-024 HOLD: if_valid=1, if_instr/if_pc stable until instr_accept.
REQ-025 HOLD with instr_accept and pc_next[1:0]==2'b00: pc<=pc_next, retire_count+=1, go to REQ; if_valid low from next cycle.
REQ-026 HOLD with instr_accept and pc_next[1:0]!=0: retire_count+=1, fault_pc<=pc_next, go to FAULT; pc unchanged.
REQ-027 instr_accept outside HOLD SHALL be ignored.
REQ-028 FAULT: fetch_fault=1, if_valid=0, no requests; exit only via rst.
REQ-029 if_valid SHALL be 1 only in HOLD; if_pc SHALL equal pc at all times.
REQ-030 retire_count SHALL be 32-bit unsigned, wrapping 32'hFFFF_FFFF -> 0.
REQ-031 Minimum loop latency: request accepted cycle N, response cycle N+1, if_valid at N+2, accept at N+2, next request at N+3.

Reset
REQ-032 While rst=1 outputs SHALL be: state REQ, pc=RESET_PC, imem_req_valid=0, if_valid=0, if_instr=0, fetch_fault=0, fault_pc=0, retire_count=0.
REQ-033 imem_req_valid SHALL assert in the first cycle after rst deasserts, imem_req_addr=RESET_PC.
REQ-034 rst asserted mid-transaction (WAIT_RSP/HOLD/FAULT) SHALL abandon it immediately; a late response after reset SHALL be ignored per REQ-023.

Verification
REQ-035 Reset release, ready=1, rsp next cycle data 32'h0000_0013 -> if_valid with if_instr=32'h13, if_pc=RESET_PC; accept with pc_next=4 -> next request addr 32'h4, retire_count=1.
REQ-036 imem_req_ready held low 5 cycles -> imem_req_valid high and addr stable all 5 cycles; no WAIT_RSP entry.
REQ-037 HOLD with pc_next=32'h0000_0102 on accept -> fetch_fault=1, fault_pc=32'h102, no further requests, if_valid=0.
REQ-038 rsp_valid with imem_rsp_err=1 at pc=32'h80 -> fetch_fault=1, fault_pc=32'h80; spurious rsp_valid/instr_accept in REQ -> no change.
REQ-039 Preload retire_count to 32'hFFFF_FFFF via 2^32 forced state or back-door, accept -> retire_count=0; rst during WAIT_RSP then late rsp -> ignored, fetch restarts at RESET_PC.
